// File: rtl/lbist_reg.sv
// lbist_reg: register-bus front end for the LBIST core. It holds the run
// configuration, runs the level-sensitive start/done handshake with the core,
// captures and checks the final signature, and raises the interrupt.
module lbist_reg #(
  parameter int RUN_CNT_W = 8
) (
  input  logic        mclk,
  input  logic        srst,
  input  logic        reg_cs,
  input  logic        reg_wr,
  input  logic [2:0]  reg_addr,
  input  logic [3:0]  reg_be,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ack,
  output logic        lbist_start,
  output logic [15:0] cfg_lbist_pat,
  output logic [15:0] cfg_chain_depth,
  output logic        lbist_srst,
  input  logic        lbist_done,
  input  logic [31:0] lbist_sig,
  output logic        lbist_intr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 ack;
  logic [31:0]          rdata;
  logic                 srst_pulse;
  logic                 done_q;
  logic                 intr_en;
  logic                 done_st;
  logic                 pass;
  logic                 fail;
  logic [RUN_CNT_W-1:0] run_cnt;
  logic [31:0]          cfg;
  logic [31:0]          sig;
  logic [31:0]          exp_sig;
  logic [31:0]          rd_val;

  logic accept;
  logic wr_acc;
  logic rd_acc;
  logic ctrl_wr;
  logic start_req;
  logic abort_req;
  logic w1c_done;
  logic busy;
  logic capture;

  // Overlay the enabled bytes of a write onto the current register value.
  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // An access is taken only while no ack is pending, so back-to-back selects
  // are served every other cycle. All side effects land on the accepting edge.
  assign accept    = reg_cs & ~ack;
  assign wr_acc    = accept & reg_wr;
  assign rd_acc    = accept & ~reg_wr;
  assign ctrl_wr   = wr_acc & (reg_addr == 3'd0) & reg_be[0];
  assign start_req = ctrl_wr & reg_wdata[0];
  assign abort_req = ctrl_wr & reg_wdata[1];
  assign w1c_done  = wr_acc & (reg_addr == 3'd1) & reg_be[0] & reg_wdata[1];
  assign busy      = (state != IDLE);
  // An abort landing on the capture cycle suppresses the capture.
  assign capture   = (state == CAPTURE) & ~abort_req;

  assign reg_ack         = ack;
  assign reg_rdata       = rdata;
  assign lbist_srst      = srst_pulse;
  assign cfg_lbist_pat   = cfg[15:0];
  assign cfg_chain_depth = cfg[31:16];
  assign lbist_intr      = intr_en & done_st;

  // State register and the single synchronising stage for the core's done level.
  always_ff @(posedge mclk) begin
    if (srst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= lbist_done;
    end
  end

  // Next-state: abort wins everywhere; ARM waits for the core to drop done.
  always_comb begin
    state_nxt = state;
    if (abort_req) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_req) state_nxt = ARM;
        ARM:     if (!done_q)   state_nxt = RUN;
        RUN:     if (done_q)    state_nxt = CAPTURE;
        CAPTURE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Start level is held through ARM and RUN and dropped for CAPTURE.
  always_comb begin
    lbist_start = (state == ARM) || (state == RUN);
  end

  // Register read mux; unmapped words read as zero.
  always_comb begin
    rd_val = '0;
    case (reg_addr)
      3'd0: rd_val[2] = intr_en;
      3'd1: begin
        rd_val[0]              = busy;
        rd_val[1]              = done_st;
        rd_val[2]              = pass;
        rd_val[3]              = fail;
        rd_val[8 +: RUN_CNT_W] = run_cnt;
      end
      3'd2:    rd_val = cfg;
      3'd3:    rd_val = sig;
      3'd4:    rd_val = exp_sig;
      default: rd_val = '0;
    endcase
  end

  // Bus response: one-cycle ack, read data only alongside it, abort pulse.
  always_ff @(posedge mclk) begin
    if (srst) begin
      ack        <= 1'b0;
      rdata      <= '0;
      srst_pulse <= 1'b0;
    end else begin
      ack        <= accept;
      rdata      <= rd_acc ? rd_val : '0;
      srst_pulse <= abort_req;
    end
  end

  // Configuration and status; config is frozen while a run is in flight.
  always_ff @(posedge mclk) begin
    if (srst) begin
      intr_en <= 1'b0;
      done_st <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      run_cnt <= '0;
      cfg     <= '0;
      sig     <= '0;
      exp_sig <= '0;
    end else begin
      if (ctrl_wr) intr_en <= reg_wdata[2];
      if (wr_acc && (reg_addr == 3'd2) && !busy) cfg     <= be_merge(cfg, reg_wdata, reg_be);
      if (wr_acc && (reg_addr == 3'd4) && !busy) exp_sig <= be_merge(exp_sig, reg_wdata, reg_be);
      if (start_req && !busy) begin
        pass <= 1'b0;
        fail <= 1'b0;
      end
      // A capture on the same edge as a DONE clear leaves DONE set.
      if (capture) begin
        sig     <= lbist_sig;
        pass    <= (lbist_sig == exp_sig);
        fail    <= (lbist_sig != exp_sig);
        done_st <= 1'b1;
        if (run_cnt != {RUN_CNT_W{1'b1}}) run_cnt <= run_cnt + 1'b1;
      end else if (w1c_done) begin
        done_st <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lbist_reg.sv
// tb_lbist_reg: randomized bench for lbist_reg with a behavioural model of the
// register block and a reactive model of the LBIST core.
module tb_lbist_reg;

  logic        mclk = 1'b0;
  logic        srst = 1'b1;
  logic        reg_cs = 1'b0;
  logic        reg_wr = 1'b0;
  logic [2:0]  reg_addr = '0;
  logic [3:0]  reg_be = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        lbist_start;
  logic [15:0] cfg_lbist_pat;
  logic [15:0] cfg_chain_depth;
  logic        lbist_srst;
  logic        lbist_done;
  logic [31:0] lbist_sig;
  logic        lbist_intr;

  always #5 mclk = ~mclk;

  lbist_reg #(.RUN_CNT_W(8)) dut (
    .mclk(mclk), .srst(srst), .reg_cs(reg_cs), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_be(reg_be), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .lbist_start(lbist_start),
    .cfg_lbist_pat(cfg_lbist_pat), .cfg_chain_depth(cfg_chain_depth),
    .lbist_srst(lbist_srst), .lbist_done(lbist_done), .lbist_sig(lbist_sig),
    .lbist_intr(lbist_intr)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  // Core behaviour knobs, set by the stimulus before each run.
  int          core_drop = 2;
  int          core_len = 20;
  logic [31:0] core_sig = '0;

  // Behavioural model state.
  logic        m_ack = 0, m_srst = 0, m_busy = 0, m_low = 0, m_cap = 0, m_dq = 0;
  logic        m_intr_en = 0, m_done = 0, m_pass = 0, m_fail = 0;
  logic [7:0]  m_cnt = '0;
  logic [31:0] m_rdata = '0, m_cfg = '0, m_sig = '0, m_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {29'd0, m_intr_en, 2'b00};
      3'd1:    return {16'd0, m_cnt, 4'd0, m_fail, m_pass, m_done, m_busy};
      3'd2:    return m_cfg;
      3'd3:    return m_sig;
      3'd4:    return m_exp;
      default: return 32'd0;
    endcase
  endfunction

  // Model: a run is "waiting for done to drop", then "waiting for done",
  // then one capture cycle; done is seen one cycle late.
  initial begin : model
    logic acc, wr, rd, ctrl, start_req, abort_req, w1c, old_busy;
    logic [31:0] rv;
    forever begin
      @(posedge mclk);
      if (srst) begin
        m_ack = 0; m_rdata = 0; m_srst = 0; m_busy = 0; m_low = 0; m_cap = 0; m_dq = 0;
        m_intr_en = 0; m_done = 0; m_pass = 0; m_fail = 0; m_cnt = 0;
        m_cfg = 0; m_sig = 0; m_exp = 0;
      end else begin
        acc       = reg_cs && !m_ack;
        wr        = acc && reg_wr;
        rd        = acc && !reg_wr;
        ctrl      = wr && reg_addr == 3'd0 && reg_be[0];
        start_req = ctrl && reg_wdata[0];
        abort_req = ctrl && reg_wdata[1];
        w1c       = wr && reg_addr == 3'd1 && reg_be[0] && reg_wdata[1];
        old_busy  = m_busy;
        rv        = rd ? model_read(reg_addr) : 32'd0;
        if (w1c) m_done = 0;
        if (ctrl) m_intr_en = reg_wdata[2];
        if (wr && reg_addr == 3'd2 && !old_busy) m_cfg = merge(m_cfg, reg_wdata, reg_be);
        if (wr && reg_addr == 3'd4 && !old_busy) m_exp = merge(m_exp, reg_wdata, reg_be);
        m_srst = abort_req;
        if (abort_req) begin
          m_busy = 0; m_cap = 0; m_low = 0;
        end else if (m_cap) begin
          m_sig  = lbist_sig;
          m_pass = (lbist_sig == m_exp);
          m_fail = !m_pass;
          m_done = 1;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          m_cap  = 0;
          m_busy = 0;
        end else if (m_busy) begin
          if (!m_low) m_low = !m_dq;
          else if (m_dq) m_cap = 1;
        end else if (start_req) begin
          m_busy = 1; m_low = 0; m_pass = 0; m_fail = 0;
        end
        m_ack   = acc;
        m_rdata = rv;
        m_dq    = lbist_done;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial begin : compare
    forever begin
      @(negedge mclk);
      if (chk_en) begin
        chk("reg_ack", reg_ack, m_ack);
        chk("reg_rdata", reg_rdata, m_rdata);
        chk("lbist_start", lbist_start, m_busy && !m_cap);
        chk("lbist_srst", lbist_srst, m_srst);
        chk("lbist_intr", lbist_intr, m_intr_en && m_done);
        chk("cfg_lbist_pat", cfg_lbist_pat, m_cfg[15:0]);
        chk("cfg_chain_depth", cfg_chain_depth, m_cfg[31:16]);
      end
    end
  end

  // Core model: drops done core_drop cycles after start rises, raises it
  // core_len cycles later with core_sig; a software reset cancels the run.
  initial begin : core
    int t;
    logic prev;
    t = -1; prev = 0; lbist_done = 0; lbist_sig = 0;
    forever begin
      @(negedge mclk);
      if (srst || lbist_srst) begin
        t = -1;
      end else begin
        if (lbist_start && !prev) t = 0;
        else if (t >= 0) t++;
        if (t >= 0 && t == core_drop) lbist_done = 0;
        if (t >= 0 && t == core_drop + core_len) begin
          lbist_done = 1; lbist_sig = core_sig; t = -1;
        end else if (t >= 0) begin
          lbist_sig = $urandom;
        end
      end
      prev = lbist_start;
    end
  end

  // Bus access; called at a falling edge, returns at the falling edge of the ack cycle.
  task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] r);
    int k;
    reg_cs = 1; reg_wr = w; reg_addr = a; reg_wdata = d; reg_be = be;
    k = 0;
    do begin
      @(posedge mclk); @(negedge mclk); k++;
    end while (!m_ack && k < 4);
    r = reg_rdata;
    reg_cs = 0; reg_wr = 0;
    if (!m_ack) begin
      n_chk++;
      $display("FAIL bus_access: no ack after %0d cycles (addr %0d)", k, a);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] dummy;
    access(1'b1, a, d, be, dummy);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] r);
    access(1'b0, a, 32'd0, 4'h0, r);
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return !m_busy;
      1:       return m_busy && m_low && !m_cap;
      default: return m_cap;
    endcase
  endfunction

  // Bounded wait on a run phase: 0 idle, 1 running, 2 capture cycle.
  task automatic wait_cond(input int sel, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (cond(sel)) break;
      @(negedge mclk);
    end
    if (!cond(sel)) begin
      n_chk++;
      $display("FAIL wait_phase_%0d: not reached within %0d cycles", sel, budget);
    end
  endtask

  initial begin : stim
    logic [31:0] r;
    logic [31:0] cur_exp;

    // Reset with the bus idle.
    repeat (3) @(posedge mclk);
    chk_en = 1;
    @(negedge mclk);
    chk("reset_start", lbist_start, 0);
    chk("reset_intr", lbist_intr, 0);
    srst = 0;
    rd_reg(3'd1, r);
    chk("reset_status", r, 32'h0000_0000);

    // Passing run.
    wr_reg(3'd2, 32'h0010_0002, 4'hF);
    wr_reg(3'd4, 32'hDEAD_BEEF, 4'hF);
    core_drop = 2; core_len = 20; core_sig = 32'hDEAD_BEEF;
    wr_reg(3'd0, 32'h5, 4'hF);
    wait_cond(0, 100);
    rd_reg(3'd3, r);
    chk("pass_sig", r, 32'hDEAD_BEEF);
    rd_reg(3'd1, r);
    chk("pass_status", r, 32'h0000_0106);
    chk("pass_intr", lbist_intr, 1);

    // Failing run.
    core_sig = 32'h1234_5678;
    wr_reg(3'd0, 32'h5, 4'hF);
    wait_cond(0, 100);
    rd_reg(3'd1, r);
    chk("fail_status", r, 32'h0000_020A);
    rd_reg(3'd3, r);
    chk("fail_sig", r, 32'h1234_5678);

    // Busy protection: config write and second START during RUN.
    core_sig = 32'hDEAD_BEEF;
    wr_reg(3'd0, 32'h5, 4'hF);
    wait_cond(1, 50);
    wr_reg(3'd2, 32'hFFFF_FFFF, 4'hF);
    wr_reg(3'd0, 32'h5, 4'hF);
    chk("busy_cfg_pat", cfg_lbist_pat, 16'h0002);
    chk("busy_cfg_depth", cfg_chain_depth, 16'h0010);
    wait_cond(0, 100);
    repeat (30) @(negedge mclk);
    rd_reg(3'd1, r);
    chk("busy_status", r, 32'h0000_0306);

    // Abort during RUN.
    wr_reg(3'd0, 32'h5, 4'hF);
    wait_cond(1, 50);
    wr_reg(3'd0, 32'h6, 4'hF);
    chk("abort_srst_hi", lbist_srst, 1);
    chk("abort_start_lo", lbist_start, 0);
    @(negedge mclk);
    chk("abort_srst_lo", lbist_srst, 0);
    rd_reg(3'd1, r);
    chk("abort_status", r, 32'h0000_0302);
    rd_reg(3'd3, r);
    chk("abort_sig", r, 32'hDEAD_BEEF);

    // Sticky DONE: clear, then W1C on the exact capture cycle.
    wr_reg(3'd1, 32'h2, 4'hF);
    rd_reg(3'd1, r);
    chk("w1c_status", r, 32'h0000_0300);
    chk("w1c_intr", lbist_intr, 0);
    core_drop = 2; core_len = 5;
    wr_reg(3'd0, 32'h5, 4'hF);
    wait_cond(2, 60);
    wr_reg(3'd1, 32'h2, 4'hF);
    wait_cond(0, 20);
    rd_reg(3'd1, r);
    chk("sticky_status", r, 32'h0000_0406);
    chk("sticky_intr", lbist_intr, 1);
    wr_reg(3'd1, 32'h2, 4'hF);
    rd_reg(3'd1, r);
    chk("clear_status", r, 32'h0000_0404);
    chk("clear_intr", lbist_intr, 0);

    // Randomized runs, enough to saturate the run counter.
    cur_exp = 32'hDEAD_BEEF;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur_exp = $urandom;
        wr_reg(3'd4, cur_exp, 4'hF);
      end
      core_drop = $urandom_range(1, 3);
      core_len  = $urandom_range(1, 6);
      core_sig  = ($urandom_range(0, 1) == 1) ? cur_exp : $urandom;
      wr_reg(3'd0, 32'h5, 4'hF);
      repeat ($urandom_range(0, 2)) rd_reg(3'($urandom), r);
      if ($urandom_range(0, 3) == 0) wr_reg(3'd2, $urandom, 4'($urandom));
      if ($urandom_range(0, 7) == 0) wr_reg(3'd1, 32'h2, 4'h1);
      wait_cond(0, 200);
    end
    rd_reg(3'd1, r);
    chk("run_cnt_sat", r[15:8], 8'hFF);

    repeat (2) @(negedge mclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lbist_reg.md
Name: lbist_reg

Overview:
- Register-bus front end for the LBIST engine; sits directly upstream of the LBIST core.
- Holds the pattern-count, chain-depth and expected-signature configuration.
- Sequences the level-sensitive start/done handshake with the core, captures the final scan signature and compares it against the expected value.
- Reports status and raises an interrupt to the SoC.

Parameters:
- RUN_CNT_W, 8, width of the completed-run counter (saturating).

Ports:
- mclk  input  1  system clock; only clock of the block.
- srst  input  1  synchronous active-high reset.
- reg_cs  input  1  register access select.
- reg_wr  input  1  1 = write, 0 = read.
- reg_addr  input  3  word address.
- reg_be  input  4  byte enables for writes.
- reg_wdata  input  32  write data.
- reg_rdata  output  32  read data, valid with reg_ack.
- reg_ack  output  1  single-cycle access acknowledge.
- lbist_start  output  1  start level to the core.
- cfg_lbist_pat  output  16  pattern count to the core.
- cfg_chain_depth  output  16  chain depth to the core.
- lbist_srst  output  1  software-reset pulse to the core.
- lbist_done  input  1  done level from the core.
- lbist_sig  input  32  signature from the core.
- lbist_intr  output  1  interrupt, level.

Behaviour:
- Clock and reset:
  - One clock (mclk). Reset is synchronous, active-high (srst).
  - On srst, all registers and outputs go to 0, including reg_ack, reg_rdata, lbist_start, lbist_srst, lbist_intr, cfg_* and the FSM (IDLE).
- Bus handshake:
  - reg_ack rises exactly 1 cycle after reg_cs=1 and stays high for 1 cycle.
  - A new access is accepted only when reg_ack=0, so back-to-back reg_cs yields an ack every other cycle.
  - Write side effects take effect on the ack cycle.
  - reg_rdata is registered on the ack cycle and is 0 otherwise.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map (word addresses):
  - 0 CTRL (W):
    - bit0 START: write 1 requests a run; self-clearing; reads 0.
    - bit1 ABORT: write 1 aborts; self-clearing; reads 0.
    - bit2 INTR_EN: RW.
  - 1 STATUS:
    - bit0 BUSY (RO).
    - bit1 DONE (sticky, W1C).
    - bit2 PASS (RO).
    - bit3 FAIL (RO).
    - bits[8+RUN_CNT_W-1:8] RUN_CNT (RO).
  - 2 CFG (RW, byte-enabled): [15:0] cfg_lbist_pat, [31:16] cfg_chain_depth.
  - 3 SIG (RO): captured signature.
  - 4 EXP_SIG (RW, byte-enabled): expected signature.
- Writes to CFG or EXP_SIG while BUSY=1 are ignored; the access is still acked.
- lbist_done is registered once (done_q) before any use.
- FSM states:
  - IDLE:
    - lbist_start=0.
    - On START write: clear PASS and FAIL, set BUSY, go to ARM.
    - START while BUSY is ignored.
  - ARM:
    - lbist_start=1.
    - Wait for done_q=0; this is the core acknowledging and clearing done from the previous run. Then go to RUN.
    - If done_q is already 0 on entry, go to RUN on the next cycle.
  - RUN:
    - lbist_start held at 1.
    - When done_q=1, go to CAPTURE.
  - CAPTURE (1 cycle):
    - SIG <= lbist_sig.
    - PASS = (lbist_sig == EXP_SIG); FAIL = !PASS.
    - DONE <= 1; RUN_CNT increments, saturating at all ones.
    - BUSY <= 0; lbist_start <= 0; go to IDLE.
- ABORT, in any state:
  - lbist_srst is a 1-cycle pulse.
  - lbist_start <= 0; BUSY <= 0; FSM goes to IDLE.
  - No capture: DONE, PASS, FAIL and SIG are unchanged.
- ABORT takes priority over START when both are written in the same word.
- W1C of DONE in the same cycle as CAPTURE: the set wins, so DONE=1.
- lbist_intr = INTR_EN & DONE.

Test Plan:
- Reset: assert srst with the bus idle. Every output is 0 and a STATUS read returns 0x0000_0000.
- Passing run:
  - Write CFG=0x0010_0002 and EXP_SIG=0xDEADBEEF, then CTRL=0x5 (START and INTR_EN).
  - Model the core: drop done 2 cycles after lbist_start rises, raise done 20 cycles later with lbist_sig=0xDEADBEEF.
  - Expect lbist_start high for the whole run, SIG=0xDEADBEEF, STATUS=0x0000_0106, lbist_intr=1.
- Failing run: same stimulus with lbist_sig=0x12345678. Expect STATUS bit3=1, bit2=0, RUN_CNT increments, SIG=0x12345678.
- Busy protection:
  - During RUN, write CFG=0xFFFF_FFFF and START again.
  - cfg outputs keep 0x0010 / 0x0002; no second run starts; both accesses are still acked after 1 cycle.
- Abort: write CTRL bit1 during RUN. Expect a single 1-cycle lbist_srst pulse, lbist_start=0 on the next cycle, BUSY=0, DONE, SIG and RUN_CNT unchanged.
- Sticky DONE:
  - Write STATUS=0x2 on the exact CAPTURE cycle: DONE stays 1.
  - A later write of 0x2 clears DONE and drops lbist_intr.
  - 256 runs leave RUN_CNT saturated at 0xFF.
